// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux
// Purpose  : Time-multiplexed scan driver for NUM_DIGITS common-anode
//            7-segment digits. Double-buffered (shadow/active) so a frame is
//            never torn by a mid-frame load. Supports per-digit blanking,
//            decimal points and leading-zero suppression.
// Ports    : clk1        system clock
//            rst         asynchronous reset, active-high
//            en          scan enable; low blanks the display, holds counters
//            load        one-cycle strobe, captures data_in/dp_in/blank_in
//            data_in     nibble per digit, digit 0 = bits [3:0] (rightmost)
//            dp_in       decimal point per digit, 1 = lit
//            blank_in    force digit dark, 1 = blank
//            lz_en       leading-zero suppression enable
//            brightness  (BRIGHT_PWM_EN only) anode duty, 0 = 1/16, 15 = full
//            dig         anode select, active-low one-hot
//            seg         segments {g,f,e,d,c,b,a}, active-low
//            dp          decimal point, active-low
//            frame_done  one-cycle pulse after each full scan
// Options  : define BRIGHT_PWM_EN to add the brightness PWM input.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_mux #(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_LOG2 = 16
) (
  input  logic                    clk1,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
`ifdef BRIGHT_PWM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [NUM_DIGITS-1:0]   dig,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int                IW         = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0]     c_LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_ONE_HOT0 = NUM_DIGITS'(1);

  logic [SCAN_DIV_LOG2-1:0] r_presc;
  logic [IW-1:0]            r_idx;
  logic [4*NUM_DIGITS-1:0]  r_sh_data,  r_act_data;
  logic [NUM_DIGITS-1:0]    r_sh_dp,    r_act_dp;
  logic [NUM_DIGITS-1:0]    r_sh_blank, r_act_blank;

  logic [SCAN_DIV_LOG2-1:0] w_presc_nxt;
  logic                     w_tick;
  logic                     w_wrap;
  logic [IW-1:0]            w_idx_nxt;
  logic [4*NUM_DIGITS-1:0]  w_act_data_nxt;
  logic [NUM_DIGITS-1:0]    w_act_dp_nxt;
  logic [NUM_DIGITS-1:0]    w_act_blank_nxt;
  logic [NUM_DIGITS-1:0]    w_lz_mask;
  logic [3:0]               w_nib;
  logic                     w_dp_bit;
  logic                     w_dark;
  logic [NUM_DIGITS-1:0]    w_dig_on;

  function automatic logic [6:0] f_hex7(input logic [3:0] nib);
    case (nib)
      4'h0: f_hex7 = 7'h40;
      4'h1: f_hex7 = 7'h79;
      4'h2: f_hex7 = 7'h24;
      4'h3: f_hex7 = 7'h30;
      4'h4: f_hex7 = 7'h19;
      4'h5: f_hex7 = 7'h12;
      4'h6: f_hex7 = 7'h02;
      4'h7: f_hex7 = 7'h78;
      4'h8: f_hex7 = 7'h00;
      4'h9: f_hex7 = 7'h10;
      4'hA: f_hex7 = 7'h08;
      4'hB: f_hex7 = 7'h03;
      4'hC: f_hex7 = 7'h46;
      4'hD: f_hex7 = 7'h21;
      4'hE: f_hex7 = 7'h06;
      default: f_hex7 = 7'h0E;
    endcase
  endfunction

  // Counter next-state. The tick that leaves the last digit is the frame wrap.
  assign w_presc_nxt = en ? (r_presc + SCAN_DIV_LOG2'(1)) : r_presc;
  assign w_tick      = en & (&r_presc);
  assign w_wrap      = w_tick & (r_idx == c_LAST_IDX);
  assign w_idx_nxt   = w_wrap ? '0 : (w_tick ? (r_idx + IW'(1)) : r_idx);

  // Active set only changes at the wrap; a load landing on the wrap bypasses
  // the shadow so it is not delayed by a whole frame.
  always_comb begin
    w_act_data_nxt  = r_act_data;
    w_act_dp_nxt    = r_act_dp;
    w_act_blank_nxt = r_act_blank;
    if (w_wrap) begin
      w_act_data_nxt  = load ? data_in  : r_sh_data;
      w_act_dp_nxt    = load ? dp_in    : r_sh_dp;
      w_act_blank_nxt = load ? blank_in : r_sh_blank;
    end
  end

  // Digit k is suppressed when it and all digits above it are zero.
  // Digit 0 is never suppressed.
  always_comb begin : p_lz
    logic v_zero;
    v_zero    = 1'b1;
    w_lz_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      v_zero       = v_zero & (w_act_data_nxt[4*k +: 4] == 4'h0);
      w_lz_mask[k] = lz_en & v_zero;
    end
  end

  // Select the fields of the digit that will be shown after this edge, so
  // outputs move together with the index.
  always_comb begin
    w_nib    = 4'h0;
    w_dp_bit = 1'b0;
    w_dark   = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_idx_nxt == IW'(k)) begin
        w_nib    = w_act_data_nxt[4*k +: 4];
        w_dp_bit = w_act_dp_nxt[k];
        w_dark   = w_act_blank_nxt[k] | w_lz_mask[k];
      end
    end
  end

  always_comb begin
    w_dig_on = ~(c_ONE_HOT0 << w_idx_nxt);
`ifdef BRIGHT_PWM_EN
    if (w_presc_nxt[SCAN_DIV_LOG2-1 -: 4] > brightness) begin
      w_dig_on = '1;
    end
`endif
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_sh_data   <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '0;
    end else begin
      r_presc     <= w_presc_nxt;
      r_idx       <= w_idx_nxt;
      r_act_data  <= w_act_data_nxt;
      r_act_dp    <= w_act_dp_nxt;
      r_act_blank <= w_act_blank_nxt;
      if (load) begin
        r_sh_data  <= data_in;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank_in;
      end
    end
  end

  // Dark digits keep their anode driven so every slot looks the same.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      dig        <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_wrap;
      if (en) begin
        dig <= w_dig_on;
        seg <= w_dark ? 7'h7F : f_hex7(w_nib);
        dp  <= ~(w_dp_bit & ~w_dark);
      end else begin
        dig <= '1;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
